gmii_rx_axis_packer: RTL and testbench

Parametrised GMII-receive to AXI4-Stream packer in the `gmii_rx_clk` domain. It assembles GMII bytes into `DATA_W`-bit beats, with an optional per-beat node/type tag byte, and buffers the beats in an internal FIFO. It drives a back-pressurable AXI4-Stream master with correct `tlast`, `tkeep` and error `tuser`. Overflow is handled frame-safely, and the block keeps frame and error counters. The clock-domain crossing to the 156.25 MHz MAC side is done downstream by a separate async FIFO.

---
 rtl/gmii_rx_axis_packer.sv | 213 +++++++++++++++++++++
 tb/tb_gmii_rx_axis_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_axis_packer.sv
// GMII receive byte stream packed into DATA_W-bit AXI4-Stream beats, with an optional
// per-beat tag byte, a frame-safe overflow path and frame/error counters.
module gmii_rx_axis_packer #(
   parameter int DATA_W     = 64,
   parameter int HDR_MODE   = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            gmii_rx_clk,
   input  logic                            rst_n,
   input  logic                            gmii_rx_dv,
   input  logic                            gmii_rx_er,
   input  logic [7:0]                      gmii_rxd,
   input  logic [3:0]                      node_id,
   input  logic [3:0]                      eth_type,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [DATA_W-1:0]               m_axis_tdata,
   output logic [DATA_W/8-1:0]             m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tuser,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [15:0]                     frame_cnt,
   output logic [15:0]                     err_cnt
);
   localparam int BYTES  = DATA_W / 8;
   localparam int LW     = $clog2(FIFO_DEPTH) + 1;
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int LANE_W = $clog2(BYTES) + 1;
   localparam int FIRST  = (HDR_MODE != 0) ? 1 : 0;
   localparam int WORD_W = DATA_W + BYTES + 2;

   typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;

   state_t              state_q, state_d;
   logic [7:0]          tag_q, tag_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [BYTES-1:0]    keep_q, keep_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic                full_q, full_d;

   logic                push_req, push_final, push, space_ok;
   logic [DATA_W-1:0]   push_data;
   logic [BYTES-1:0]    push_keep;
   logic                push_last, push_user;
   logic                ins_en;
   logic [LANE_W-1:0]   ins_lane;
   logic [DATA_W-1:0]   ins_data;
   logic [BYTES-1:0]    ins_keep;

   logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       mem_cnt_q, mem_cnt_d, level_q, level_d;
   logic                out_valid_q, out_valid_d;
   logic [WORD_W-1:0]   out_word_q, out_word_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
   logic                pop_out, load;

   function automatic logic [DATA_W-1:0] tag_beat(input logic [7:0] t);
      tag_beat = '0;
      if (HDR_MODE != 0) tag_beat[7:0] = t;
   endfunction

   always_comb begin
      state_d    = state_q;
      tag_d      = tag_q;
      err_d      = err_q;
      acc_d      = acc_q;
      keep_d     = keep_q;
      lane_d     = lane_q;
      full_d     = full_q;
      push_req   = 1'b0;
      push_final = 1'b0;
      push_data  = acc_q;
      push_keep  = keep_q;
      push_last  = 1'b0;
      push_user  = 1'b0;
      ins_en     = 1'b0;
      ins_lane   = lane_q;
      ins_data   = acc_q;
      ins_keep   = keep_q;
      space_ok   = 1'b0;
      push       = 1'b0;

      case (state_q)
         SYNC: if (!gmii_rx_dv) state_d = IDLE;
         IDLE: begin
            if (gmii_rx_dv) begin
               tag_d    = {node_id, eth_type};
               err_d    = gmii_rx_er;
               ins_en   = 1'b1;
               ins_lane = LANE_W'(FIRST);
               ins_data = tag_beat({node_id, eth_type});
               ins_keep = BYTES'(FIRST);
               state_d  = RECV;
            end
         end
         RECV: begin
            if (gmii_rx_dv) begin
               if (gmii_rx_er) err_d = 1'b1;
               if (full_q) begin
                  push_req = 1'b1;
                  ins_lane = LANE_W'(FIRST);
                  ins_data = tag_beat(tag_q);
                  ins_keep = BYTES'(FIRST);
               end
               ins_en = 1'b1;
            end else begin
               push_req   = 1'b1;
               push_final = 1'b1;
               push_last  = 1'b1;
               push_user  = err_q;
               state_d    = IDLE;
            end
         end
         DROP: begin
            if (!gmii_rx_dv) begin
               push_req   = 1'b1;
               push_final = 1'b1;
               push_data  = tag_beat(tag_q);
               push_keep  = BYTES'(1);
               push_last  = 1'b1;
               push_user  = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = SYNC;
      endcase

      // One slot stays reserved for a frame's closing beat so every frame gets tlast.
      space_ok = push_final ? (level_q <= LW'(FIFO_DEPTH - 1)) : (level_q < LW'(FIFO_DEPTH - 1));
      push     = push_req & space_ok;

      if (push_req && !push_final && !space_ok) begin
         ins_en  = 1'b0;
         state_d = DROP;
      end

      if (ins_en) begin
         acc_d = ins_data;
         for (int i = 0; i < BYTES; i++)
            if (ins_lane == LANE_W'(i)) acc_d[i*8 +: 8] = gmii_rxd;
         keep_d = ins_keep | (BYTES'(1) << ins_lane);
         lane_d = ins_lane + LANE_W'(1);
         full_d = (ins_lane == LANE_W'(BYTES - 1));
      end
   end

   // Output handshake: a beat transfers on a rising edge where m_axis_tvalid and
   // m_axis_tready are both 1; tvalid never depends on tready and the beat is held until taken.
   always_comb begin
      pop_out     = out_valid_q & m_axis_tready;
      load        = (mem_cnt_q != '0) & (~out_valid_q | m_axis_tready);
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = load ? rd_ptr_q + PW'(1) : rd_ptr_q;
      mem_cnt_d   = mem_cnt_q + LW'(push) - LW'(load);
      level_d     = level_q + LW'(push) - LW'(pop_out);
      out_valid_d = load ? 1'b1 : (pop_out ? 1'b0 : out_valid_q);
      out_word_d  = load ? mem_q[rd_ptr_q] : out_word_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (pop_out && out_word_q[WORD_W-2]) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         if (out_word_q[WORD_W-1]) err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge gmii_rx_clk) begin
      if (push) mem_q[wr_ptr_q] <= {push_user, push_last, push_keep, push_data};
   end

   always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SYNC;
         tag_q       <= '0;
         err_q       <= 1'b0;
         acc_q       <= '0;
         keep_q      <= '0;
         lane_q      <= '0;
         full_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
         keep_q      <= keep_d;
         lane_q      <= lane_d;
         full_q      <= full_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign m_axis_tvalid = out_valid_q;
   assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_word_q;
   assign fifo_level    = level_q;
   assign frame_cnt     = frame_cnt_q;
   assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_gmii_rx_axis_packer.sv
// Directed bench for gmii_rx_axis_packer: instance a (mode 0, depth 4) and instance b
// (mode 1, depth 8) share one GMII driver; per-instance expected queues feed two monitors.
module tb_gmii_rx_axis_packer;
   localparam int W = 74;

   logic clk = 1'b0;
   always #4 clk = ~clk;

   logic       rst_n;
   logic       dv, er;
   logic [7:0] rxd;
   int         sel;
   logic       dv_a, dv_b, er_a, er_b;

   assign dv_a = dv & (sel == 0);
   assign dv_b = dv & (sel == 1);
   assign er_a = er & (sel == 0);
   assign er_b = er & (sel == 1);

   logic        a_tvalid, a_tready, a_tlast, a_tuser;
   logic [63:0] a_tdata;
   logic [7:0]  a_tkeep;
   logic [2:0]  a_level;
   logic [15:0] a_frame_cnt, a_err_cnt;
   logic        b_tvalid, b_tready, b_tlast, b_tuser;
   logic [63:0] b_tdata;
   logic [7:0]  b_tkeep;
   logic [3:0]  b_level;
   logic [15:0] b_frame_cnt, b_err_cnt;

   gmii_rx_axis_packer #(.DATA_W(64), .HDR_MODE(0), .FIFO_DEPTH(4)) dut_a (
      .gmii_rx_clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv_a), .gmii_rx_er(er_a), .gmii_rxd(rxd),
      .node_id(4'h3), .eth_type(4'h5), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
      .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tlast(a_tlast),
      .m_axis_tuser(a_tuser), .fifo_level(a_level), .frame_cnt(a_frame_cnt), .err_cnt(a_err_cnt)
   );

   gmii_rx_axis_packer #(.DATA_W(64), .HDR_MODE(1), .FIFO_DEPTH(8)) dut_b (
      .gmii_rx_clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv_b), .gmii_rx_er(er_b), .gmii_rxd(rxd),
      .node_id(4'h3), .eth_type(4'h5), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
      .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
      .m_axis_tuser(b_tuser), .fifo_level(b_level), .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt)
   );

   logic [W-1:0] exp_a[$];
   logic [W-1:0] exp_b[$];
   int checks   = 0;
   int failures = 0;

   function automatic logic [W-1:0] beat(input logic [63:0] d, input logic [7:0] k,
                                         input logic l, input logic u);
      return {u, l, k, d};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: compare every accepted beat against the head of its queue.
   always @(negedge clk) begin
      if (rst_n && a_tvalid && a_tready) begin
         if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_unexpected: got %h expected no beat",
                     beat(a_tdata, a_tkeep, a_tlast, a_tuser));
         end else begin
            check("a_beat", beat(a_tdata, a_tkeep, a_tlast, a_tuser), exp_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_tvalid && b_tready) begin
         if (exp_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_unexpected: got %h expected no beat",
                     beat(b_tdata, b_tkeep, b_tlast, b_tuser));
         end else begin
            check("b_beat", beat(b_tdata, b_tkeep, b_tlast, b_tuser), exp_b.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      dv = 1'b0; er = 1'b0; rxd = 8'h00;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic send_frame(input int s, input int n, input logic [7:0] base,
                             input int er_idx, input int ipg);
      sel = s;
      for (int i = 0; i < n; i++) begin
         dv  = 1'b1;
         er  = (i == er_idx);
         rxd = base + 8'(i);
         tick();
      end
      dv = 1'b0; er = 1'b0; rxd = 8'h00;
      repeat (ipg) tick();
   endtask

   task automatic wait_drain(input int s);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (s == 0) done = (exp_a.size() == 0) && !a_tvalid;
         else        done = (exp_b.size() == 0) && !b_tvalid;
         if (!done) tick();
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL drain_timeout: instance %0d still has %0d beats outstanding", s,
                  (s == 0) ? exp_a.size() : exp_b.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 0; a_tready = 1'b1; b_tready = 1'b1;
      do_reset();

      // reset state
      check("rst_a_tvalid", W'(a_tvalid), W'(0));
      check("rst_a_tdata",  W'(a_tdata),  W'(0));
      check("rst_a_tkeep",  W'(a_tkeep),  W'(0));
      check("rst_a_tlast",  W'(a_tlast),  W'(0));
      check("rst_a_tuser",  W'(a_tuser),  W'(0));
      check("rst_a_level",  W'(a_level),  W'(0));
      check("rst_a_frames", W'(a_frame_cnt), W'(0));
      check("rst_a_errs",   W'(a_err_cnt), W'(0));
      check("rst_b_tvalid", W'(b_tvalid), W'(0));
      check("rst_b_level",  W'(b_level),  W'(0));

      // two full beats, mode 0
      exp_a.push_back(beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0));
      exp_a.push_back(beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 1'b0));
      send_frame(0, 16, 8'h00, -1, 4);
      wait_drain(0);
      check("t1_frame_cnt", W'(a_frame_cnt), W'(1));
      check("t1_err_cnt",   W'(a_err_cnt),   W'(0));

      // tagged frame, mode 1
      exp_b.push_back(beat(64'h0706050403020135, 8'hFF, 1'b0, 1'b0));
      exp_b.push_back(beat(64'h000000000A090835, 8'h0F, 1'b1, 1'b0));
      send_frame(1, 10, 8'h01, -1, 4);
      wait_drain(1);
      check("t2_frame_cnt", W'(b_frame_cnt), W'(1));

      // receive error on byte 3
      do_reset();
      exp_a.push_back(beat(64'h1716151413121110, 8'hFF, 1'b1, 1'b1));
      send_frame(0, 8, 8'h10, 3, 4);
      wait_drain(0);
      check("t3_err_cnt",   W'(a_err_cnt),   W'(1));
      check("t3_frame_cnt", W'(a_frame_cnt), W'(1));

      // overflow with depth 4 and a stalled sink
      do_reset();
      a_tready = 1'b0;
      exp_a.push_back(beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0));
      exp_a.push_back(beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0));
      exp_a.push_back(beat(64'h1716151413121110, 8'hFF, 1'b0, 1'b0));
      exp_a.push_back(beat(64'h0, 8'h01, 1'b1, 1'b1));
      send_frame(0, 64, 8'h00, -1, 2);
      check("t4_level", W'(a_level), W'(4));
      for (int i = 0; i < 3; i++) begin
         check("t4_stall_valid", W'(a_tvalid), W'(1));
         check("t4_stall_beat", beat(a_tdata, a_tkeep, a_tlast, a_tuser),
               beat(64'h0706050403020100, 8'hFF, 1'b0, 1'b0));
         tick();
      end
      a_tready = 1'b1;
      wait_drain(0);
      check("t4_err_cnt",   W'(a_err_cnt),   W'(1));
      check("t4_frame_cnt", W'(a_frame_cnt), W'(1));
      check("t4_level_end", W'(a_level),     W'(0));

      // reset asserted and released mid-frame
      do_reset();
      a_tready = 1'b0;
      sel = 0;
      for (int i = 0; i < 12; i++) begin
         dv = 1'b1; rxd = 8'h20 + 8'(i); tick();
      end
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rxd = 8'h40 + 8'(i); tick();
      end
      rst_n = 1'b1;
      a_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rxd = 8'h50 + 8'(i); tick();
      end
      check("t5_level_rst", W'(a_level),  W'(0));
      check("t5_no_valid",  W'(a_tvalid), W'(0));
      dv = 1'b0; rxd = 8'h00;
      repeat (2) tick();
      exp_a.push_back(beat(64'h0000000000A3A2A1, 8'h07, 1'b1, 1'b0));
      send_frame(0, 3, 8'hA1, -1, 4);
      wait_drain(0);
      check("t5_frame_cnt", W'(a_frame_cnt), W'(1));

      // 1-byte frame, 1-cycle IPG, 8-byte frame, mode 1
      exp_b.push_back(beat(64'h0000000000005535, 8'h03, 1'b1, 1'b0));
      exp_b.push_back(beat(64'h6665646362616035, 8'hFF, 1'b0, 1'b0));
      exp_b.push_back(beat(64'h0000000000006735, 8'h03, 1'b1, 1'b0));
      send_frame(1, 1, 8'h55, -1, 1);
      send_frame(1, 8, 8'h60, -1, 4);
      wait_drain(1);
      check("t6_frame_cnt", W'(b_frame_cnt), W'(2));
      check("t6_err_cnt",   W'(b_err_cnt),   W'(0));

      check("end_queue_a", W'(exp_a.size()), W'(0));
      check("end_queue_b", W'(exp_b.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
